ysyx_23060184_bus_arbiter: RTL and testbench
============================================

// Module: ysyx_23060184_bus_arbiter
// PURPOSE
//  N-master, M-slave bus arbiter with address decode, per-slave access control and bus lock.
//  Successor to the fixed 2-master IFU/LSU arbiter.
//  Sits between the fetch/load-store masters (plus future DMA) and the memory-mapped
//  slaves (SRAM, UART, ...).
//  Grant is held for the whole transaction until the owner signals done.
//  A watchdog releases a hung bus.
// PARAMETERS
//  NUM_MASTERS  2                 masters; index 0 = IFU, 1 = LSU
//  NUM_SLAVES   2                 decoded slave regions
//  ADDR_WIDTH   32                address width per master
//  ARB_MODE     0                 0 = fixed priority (lowest index wins); 1 = round-robin
//  SLV_BASE     {32'hA000_03F8,32'h8000_0000}  packed region bases; slave 0 in LSBs
//  SLV_LAST     {32'hA000_03FF,32'h87FF_FFFF}  packed inclusive region ends
//  SLV_ACCESS   {2'b10,2'b11}     packed per-slave master-permission masks; UART is LSU-only
//  TIMEOUT      1024              max BUSY cycles before forced release; 0 = watchdog off
// PORTS
//  clk       in   1                 clock
//  rst       in   1                 synchronous, active-high reset
//  m_req     in   NUM_MASTERS       per-master request level
//  m_addr    in   NUM_MASTERS*AW    packed request addresses; master 0 in LSBs
//  m_done    in   NUM_MASTERS       per-master transaction-complete pulse
//  grant     out  NUM_MASTERS       one-hot owner; 0 = bus free
//  slv_sel   out  NUM_SLAVES        one-hot selected slave; 0 on decode error
//  dec_err   out  1                 granted access hit no region or was not permitted
//  timeout   out  1                 1-cycle pulse when the watchdog forces release
//  busy      out  1                 FSM in BUSY
// BEHAVIOUR
//  Reset: grant=0, slv_sel=0, dec_err=0, timeout=0, busy=0, FSM=IDLE, rr_ptr=0, wdog=0.
//   Reset mid-transaction drops the grant at the next edge with no done required.
//  FSM IDLE:
//   - Any m_req set: pick winner W.
//   - At that edge: register grant=1<<W, slv_sel/dec_err from decode of m_addr[W],
//     wdog=0, go BUSY.
//   - Latency: m_req to grant is 1 cycle.
//  FSM BUSY:
//   - Outputs are held constant.
//   - m_req and m_addr of every master are ignored, including W dropping m_req.
//   - m_done[W]=1: next edge grant=0, slv_sel=0, dec_err=0, go IDLE.
//   - m_done of non-owners is ignored.
//   - Minimum one IDLE cycle between grants.
//  Arbitration:
//   - ARB_MODE=0: lowest set index wins.
//   - ARB_MODE=1: first set index at or after rr_ptr, wrapping modulo NUM_MASTERS.
//     rr_ptr <= (W+1) mod NUM_MASTERS on each grant.
//  Decode:
//   - Region i hits when SLV_BASE[i] <= addr <= SLV_LAST[i], unsigned ADDR_WIDTH compare.
//   - Overlapping regions: lowest i wins.
//   - No hit, or SLV_ACCESS[i][W]=0: slv_sel=0, dec_err=1.
//   - The grant is still issued, so the master completes with an error response and must
//     still assert m_done.
//  Watchdog (TIMEOUT>0):
//   - wdog increments each BUSY cycle without m_done[W].
//   - When wdog reaches TIMEOUT-1 with no done: next edge go IDLE with all outputs cleared,
//     and timeout=1 for exactly that cycle.
//   - m_done in the same cycle takes precedence: normal release, no timeout pulse.
//   - Counter width is $clog2(TIMEOUT+1).
// TESTING
//  1. Reset, m_req=01, m_addr0=0x8000_0000, done at cycle 4 -> grant=01, slv_sel=01 at cycle 1;
//     grant=00 at cycle 5.
//  2. ARB_MODE=0, m_req=11 held -> grants alternate 01, idle, 01, ...
//     Master 1 is never served while master 0 is requesting.
//  3. ARB_MODE=1, m_req=11 held, done each 2 cycles -> grant sequence 01, 10, 01, 10
//     with one idle cycle between.
//  4. Master 0 addr 0xA000_03F8 -> grant=01, slv_sel=00, dec_err=1.
//     Master 1 same addr -> slv_sel=10, dec_err=0.
//  5. Addr 0x0000_1000, or 0xA000_0400 just past UART -> dec_err=1; done releases normally.
//  6. TIMEOUT=8, no done -> timeout pulses 8 cycles after grant, grant=00.
//     Rerun with done at the same cycle -> no timeout pulse.
//     Assert rst while BUSY -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/ysyx_23060184_bus_arbiter.sv
// N-master / M-slave bus arbiter: fixed-priority or round-robin grant, address decode
// with per-slave master permissions, grant held until owner done, watchdog release.
module ysyx_23060184_bus_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES  = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int ARB_MODE    = 0,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0]  SLV_BASE   = {32'hA000_03F8, 32'h8000_0000},
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0]  SLV_LAST   = {32'hA000_03FF, 32'h87FF_FFFF},
  parameter logic [NUM_SLAVES*NUM_MASTERS-1:0] SLV_ACCESS = {2'b10, 2'b11},
  parameter int TIMEOUT     = 1024
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_MASTERS-1:0]            m_req,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
  input  logic [NUM_MASTERS-1:0]            m_done,
  output logic [NUM_MASTERS-1:0]            grant,
  output logic [NUM_SLAVES-1:0]             slv_sel,
  output logic                              dec_err,
  output logic                              timeout,
  output logic                              busy
);

  localparam int MW  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e                  state_q, state_d;
  logic [NUM_MASTERS-1:0]  grant_q, grant_d;
  logic [NUM_SLAVES-1:0]   slvSel_q, slvSel_d;
  logic                    decErr_q, decErr_d;
  logic                    timeout_q, timeout_d;
  logic [WDW-1:0]          wdog_q, wdog_d;
  logic [MW-1:0]           rrPtr_q, rrPtr_d;

  logic                    winFound;
  logic [MW-1:0]           winIdx;
  logic [MW-1:0]           cand;
  logic [MW:0]             candWide;
  logic [NUM_MASTERS-1:0]  winOh;
  logic [ADDR_WIDTH-1:0]   winAddr;
  logic                    hitAllowed;
  logic [NUM_SLAVES-1:0]   hitOh;
  logic                    ownerDone;
  logic                    wdogExpired;

  // Scan candidates from last to first so the earliest in search order is kept.
  always_comb begin
    winFound = 1'b0;
    winIdx   = '0;
    winOh    = '0;
    cand     = '0;
    candWide = '0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      if (ARB_MODE == 0) begin
        cand = MW'(k);
      end else begin
        candWide = {1'b0, rrPtr_q} + (MW + 1)'(k);
        if (candWide >= (MW + 1)'(NUM_MASTERS)) candWide = candWide - (MW + 1)'(NUM_MASTERS);
        cand = candWide[MW-1:0];
      end
      if (m_req[cand]) begin
        winFound    = 1'b1;
        winIdx      = cand;
        winOh       = '0;
        winOh[cand] = 1'b1;
      end
    end
    winAddr = '0;
    for (int j = 0; j < NUM_MASTERS; j++) begin
      if (winOh[j]) winAddr = m_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  always_comb begin
    hitAllowed = 1'b0;
    hitOh      = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (winAddr >= SLV_BASE[i*ADDR_WIDTH +: ADDR_WIDTH] &&
          winAddr <= SLV_LAST[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
        hitOh      = '0;
        hitOh[i]   = 1'b1;
        hitAllowed = |(SLV_ACCESS[i*NUM_MASTERS +: NUM_MASTERS] & winOh);
      end
    end
  end

  assign ownerDone   = |(m_done & grant_q);
  assign wdogExpired = (TIMEOUT > 0) && (wdog_q == WDW'(TIMEOUT - 1));

  // A done in the expiry cycle wins over the watchdog, so no timeout pulse then.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    slvSel_d  = slvSel_q;
    decErr_d  = decErr_q;
    timeout_d = 1'b0;
    wdog_d    = wdog_q;
    rrPtr_d   = rrPtr_q;
    unique case (state_q)
      IDLE: begin
        if (winFound) begin
          state_d  = BUSY;
          grant_d  = winOh;
          slvSel_d = hitAllowed ? hitOh : '0;
          decErr_d = !hitAllowed;
          wdog_d   = '0;
          rrPtr_d  = (winIdx == MW'(NUM_MASTERS - 1)) ? '0 : winIdx + 1'b1;
        end
      end
      BUSY: begin
        if (ownerDone || wdogExpired) begin
          state_d   = IDLE;
          grant_d   = '0;
          slvSel_d  = '0;
          decErr_d  = 1'b0;
          timeout_d = !ownerDone;
          wdog_d    = '0;
        end else if (TIMEOUT > 0) begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      slvSel_q  <= '0;
      decErr_q  <= 1'b0;
      timeout_q <= 1'b0;
      wdog_q    <= '0;
      rrPtr_q   <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      slvSel_q  <= slvSel_d;
      decErr_q  <= decErr_d;
      timeout_q <= timeout_d;
      wdog_q    <= wdog_d;
      rrPtr_q   <= rrPtr_d;
    end
  end

  assign grant   = grant_q;
  assign slv_sel = slvSel_q;
  assign dec_err = decErr_q;
  assign timeout = timeout_q;
  assign busy    = (state_q == BUSY);

endmodule

// File: tb/tb_ysyx_23060184_bus_arbiter.sv
// Bench for the bus arbiter: dut0 is fixed priority, dut1 round-robin, both with an
// 8-cycle watchdog. Expected output events are queued with the cycle they must appear in.
module tb_ysyx_23060184_bus_arbiter;

  typedef struct {
    int         dut;
    int         cycle;
    logic [1:0] grant;
    logic [1:0] sel;
    logic       err;
    logic       to;
    logic       bsy;
    string      name;
  } expEvt_t;

  logic        clk;
  logic        rst;
  logic [1:0]  mReq   [2];
  logic [63:0] mAddr  [2];
  logic [1:0]  mDone  [2];
  logic [1:0]  grantS [2];
  logic [1:0]  selS   [2];
  logic        errS   [2];
  logic        toS    [2];
  logic        busyS  [2];

  expEvt_t     expQ[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          monOn = 1'b0;
  logic [5:0]  prevOut [2];
  logic [5:0]  curOut;
  bit          due;

  ysyx_23060184_bus_arbiter #(.NUM_MASTERS(2), .NUM_SLAVES(2), .ADDR_WIDTH(32),
                              .ARB_MODE(0), .TIMEOUT(8)) dut0 (
    .clk(clk), .rst(rst), .m_req(mReq[0]), .m_addr(mAddr[0]), .m_done(mDone[0]),
    .grant(grantS[0]), .slv_sel(selS[0]), .dec_err(errS[0]), .timeout(toS[0]), .busy(busyS[0])
  );

  ysyx_23060184_bus_arbiter #(.NUM_MASTERS(2), .NUM_SLAVES(2), .ADDR_WIDTH(32),
                              .ARB_MODE(1), .TIMEOUT(8)) dut1 (
    .clk(clk), .rst(rst), .m_req(mReq[1]), .m_addr(mAddr[1]), .m_done(mDone[1]),
    .grant(grantS[1]), .slv_sel(selS[1]), .dec_err(errS[1]), .timeout(toS[1]), .busy(busyS[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic pushExpect(input int d, input logic [1:0] g, input logic [1:0] s,
                            input logic e, input logic t, input string name);
    expEvt_t ev;
    ev.dut = d; ev.cycle = cyc; ev.grant = g; ev.sel = s; ev.err = e; ev.to = t;
    ev.bsy = |g; ev.name = name;
    expQ.push_back(ev);
  endtask

  task automatic applyStimulus(input int d, input logic [1:0] req, input logic [31:0] a0,
                               input logic [31:0] a1, input logic [1:0] done);
    mReq[d]    = req;
    mAddr[d]   = {a1, a0};
    mDone[d]   = done;
    mReq[1-d]  = '0;
    mAddr[1-d] = '0;
    mDone[1-d] = '0;
    @(posedge clk);
    #1;
  endtask

  task automatic finishXfer(input int d, input logic [1:0] done, input string name);
    applyStimulus(d, 2'b00, 32'h0, 32'h0, done);
    pushExpect(d, 2'b00, 2'b00, 1'b0, 1'b0, name);
  endtask

  task automatic checkOutput(input int d);
    expEvt_t e;
    checks++;
    if (expQ.size() == 0) begin
      errors++;
      $display("[TB] FAIL unexpected_event dut%0d cyc %0d: got grant=%b sel=%b err=%b to=%b busy=%b, no event required",
               d, cyc, grantS[d], selS[d], errS[d], toS[d], busyS[d]);
    end else begin
      e = expQ.pop_front();
      if (e.dut != d || e.cycle != cyc || grantS[d] !== e.grant || selS[d] !== e.sel ||
          errS[d] !== e.err || toS[d] !== e.to || busyS[d] !== e.bsy) begin
        errors++;
        $display("[TB] FAIL %s: got dut%0d cyc %0d grant=%b sel=%b err=%b to=%b busy=%b, required dut%0d cyc %0d grant=%b sel=%b err=%b to=%b busy=%b",
                 e.name, d, cyc, grantS[d], selS[d], errS[d], toS[d], busyS[d],
                 e.dut, e.cycle, e.grant, e.sel, e.err, e.to, e.bsy);
      end
    end
  endtask

  // Any output change, a timeout pulse, or a due expectation is an event to score.
  always @(negedge clk) begin
    if (monOn) begin
      for (int d = 0; d < 2; d++) begin
        curOut = {grantS[d], selS[d], errS[d], busyS[d]};
        due = (expQ.size() > 0) && (expQ[0].dut == d) && (expQ[0].cycle <= cyc);
        if (curOut != prevOut[d] || toS[d] || due) checkOutput(d);
        prevOut[d] = curOut;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL sim_time_limit: got no end of stimulus, required finish");
    $fatal(1, "[TB] time limit");
  end

  initial begin
    prevOut[0] = '0;
    prevOut[1] = '0;
    for (int d = 0; d < 2; d++) begin
      mReq[d] = '0; mAddr[d] = '0; mDone[d] = '0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    monOn = 1'b1;
    pushExpect(0, 2'b00, 2'b00, 1'b0, 1'b0, "reset_dut0");
    pushExpect(1, 2'b00, 2'b00, 1'b0, 1'b0, "reset_dut1");
    rst = 1'b0;

    // basic SRAM transfer, grant one cycle after request, release one after done
    applyStimulus(0, 2'b01, 32'h8000_0000, 32'h0, 2'b00);
    pushExpect(0, 2'b01, 2'b01, 1'b0, 1'b0, "t1_grant");
    repeat (3) applyStimulus(0, 2'b01, 32'h8000_0000, 32'h0, 2'b00);
    finishXfer(0, 2'b01, "t1_release");
    applyStimulus(0, 2'b00, 32'h0, 32'h0, 2'b00);

    // fixed priority with both requesting: master 0 every time, idle cycle between
    applyStimulus(0, 2'b11, 32'h8000_0010, 32'h8000_0020, 2'b00);
    pushExpect(0, 2'b01, 2'b01, 1'b0, 1'b0, "t2_grant_a");
    applyStimulus(0, 2'b11, 32'h0000_1000, 32'h8000_0020, 2'b10);
    applyStimulus(0, 2'b11, 32'h8000_0010, 32'h8000_0020, 2'b01);
    pushExpect(0, 2'b00, 2'b00, 1'b0, 1'b0, "t2_rel_a");
    applyStimulus(0, 2'b11, 32'h8000_0010, 32'h8000_0020, 2'b00);
    pushExpect(0, 2'b01, 2'b01, 1'b0, 1'b0, "t2_grant_b");
    applyStimulus(0, 2'b11, 32'h8000_0010, 32'h8000_0020, 2'b01);
    pushExpect(0, 2'b00, 2'b00, 1'b0, 1'b0, "t2_rel_b");
    applyStimulus(0, 2'b11, 32'h8000_0010, 32'h8000_0020, 2'b00);
    pushExpect(0, 2'b01, 2'b01, 1'b0, 1'b0, "t2_grant_c");
    finishXfer(0, 2'b01, "t2_rel_c");

    // UART permission and region boundaries
    applyStimulus(0, 2'b01, 32'hA000_03F8, 32'h0, 2'b00);
    pushExpect(0, 2'b01, 2'b00, 1'b1, 1'b0, "t4_uart_m0_denied");
    finishXfer(0, 2'b01, "t4_rel_m0");
    applyStimulus(0, 2'b10, 32'h0, 32'hA000_03F8, 2'b00);
    pushExpect(0, 2'b10, 2'b10, 1'b0, 1'b0, "t4_uart_m1");
    finishXfer(0, 2'b10, "t4_rel_m1");
    applyStimulus(0, 2'b10, 32'h0, 32'hA000_03FF, 2'b00);
    pushExpect(0, 2'b10, 2'b10, 1'b0, 1'b0, "t4_uart_last");
    finishXfer(0, 2'b10, "t4_rel_last");
    applyStimulus(0, 2'b01, 32'h87FF_FFFF, 32'h0, 2'b00);
    pushExpect(0, 2'b01, 2'b01, 1'b0, 1'b0, "t4_sram_last");
    finishXfer(0, 2'b01, "t4_rel_sram");

    // decode errors still grant and release normally
    applyStimulus(0, 2'b01, 32'h0000_1000, 32'h0, 2'b00);
    pushExpect(0, 2'b01, 2'b00, 1'b1, 1'b0, "t5_unmapped");
    finishXfer(0, 2'b01, "t5_rel_unmapped");
    applyStimulus(0, 2'b10, 32'h0, 32'hA000_0400, 2'b00);
    pushExpect(0, 2'b10, 2'b00, 1'b1, 1'b0, "t5_past_uart");
    finishXfer(0, 2'b10, "t5_rel_past_uart");
    applyStimulus(0, 2'b01, 32'h7FFF_FFFF, 32'h0, 2'b00);
    pushExpect(0, 2'b01, 2'b00, 1'b1, 1'b0, "t5_below_sram");
    finishXfer(0, 2'b01, "t5_rel_below_sram");

    // round-robin on dut1
    applyStimulus(1, 2'b11, 32'h8000_0100, 32'h8000_0200, 2'b00);
    pushExpect(1, 2'b01, 2'b01, 1'b0, 1'b0, "t3_rr_a");
    applyStimulus(1, 2'b11, 32'h8000_0100, 32'h8000_0200, 2'b00);
    applyStimulus(1, 2'b11, 32'h8000_0100, 32'h8000_0200, 2'b01);
    pushExpect(1, 2'b00, 2'b00, 1'b0, 1'b0, "t3_rel_a");
    applyStimulus(1, 2'b11, 32'h8000_0100, 32'h8000_0200, 2'b00);
    pushExpect(1, 2'b10, 2'b01, 1'b0, 1'b0, "t3_rr_b");
    applyStimulus(1, 2'b11, 32'h8000_0100, 32'h8000_0200, 2'b01);
    applyStimulus(1, 2'b11, 32'h8000_0100, 32'h8000_0200, 2'b10);
    pushExpect(1, 2'b00, 2'b00, 1'b0, 1'b0, "t3_rel_b");
    applyStimulus(1, 2'b11, 32'h8000_0100, 32'h8000_0200, 2'b00);
    pushExpect(1, 2'b01, 2'b01, 1'b0, 1'b0, "t3_rr_c");
    applyStimulus(1, 2'b11, 32'h8000_0100, 32'h8000_0200, 2'b00);
    applyStimulus(1, 2'b11, 32'h8000_0100, 32'h8000_0200, 2'b01);
    pushExpect(1, 2'b00, 2'b00, 1'b0, 1'b0, "t3_rel_c");
    applyStimulus(1, 2'b11, 32'h8000_0100, 32'h8000_0200, 2'b00);
    pushExpect(1, 2'b10, 2'b01, 1'b0, 1'b0, "t3_rr_d");
    applyStimulus(1, 2'b11, 32'h8000_0100, 32'h8000_0200, 2'b00);
    finishXfer(1, 2'b10, "t3_rel_d");
    applyStimulus(1, 2'b10, 32'h0, 32'h8000_0200, 2'b00);
    pushExpect(1, 2'b10, 2'b01, 1'b0, 1'b0, "t3_rr_skip");
    finishXfer(1, 2'b10, "t3_rel_skip");
    applyStimulus(1, 2'b01, 32'h8000_0100, 32'h0, 2'b00);
    pushExpect(1, 2'b01, 2'b01, 1'b0, 1'b0, "t3_rr_e");
    finishXfer(1, 2'b01, "t3_rel_e");
    applyStimulus(1, 2'b01, 32'h8000_0100, 32'h0, 2'b00);
    pushExpect(1, 2'b01, 2'b01, 1'b0, 1'b0, "t3_rr_wrap");
    finishXfer(1, 2'b01, "t3_rel_wrap");

    // watchdog expiry, done on the expiry cycle, reset while busy
    applyStimulus(0, 2'b01, 32'h8000_0000, 32'h0, 2'b00);
    pushExpect(0, 2'b01, 2'b01, 1'b0, 1'b0, "t6_grant");
    repeat (7) applyStimulus(0, 2'b00, 32'h0, 32'h0, 2'b00);
    applyStimulus(0, 2'b00, 32'h0, 32'h0, 2'b00);
    pushExpect(0, 2'b00, 2'b00, 1'b0, 1'b1, "t6_timeout");
    applyStimulus(0, 2'b00, 32'h0, 32'h0, 2'b00);
    applyStimulus(0, 2'b01, 32'h8000_0000, 32'h0, 2'b00);
    pushExpect(0, 2'b01, 2'b01, 1'b0, 1'b0, "t6_grant_done");
    repeat (7) applyStimulus(0, 2'b00, 32'h0, 32'h0, 2'b00);
    finishXfer(0, 2'b01, "t6_done_at_limit");
    applyStimulus(0, 2'b00, 32'h0, 32'h0, 2'b00);
    applyStimulus(0, 2'b01, 32'h8000_0000, 32'h0, 2'b00);
    pushExpect(0, 2'b01, 2'b01, 1'b0, 1'b0, "t6_rst_grant");
    applyStimulus(0, 2'b01, 32'h8000_0000, 32'h0, 2'b00);
    rst = 1'b1;
    applyStimulus(0, 2'b01, 32'h8000_0000, 32'h0, 2'b00);
    pushExpect(0, 2'b00, 2'b00, 1'b0, 1'b0, "t6_rst_busy");
    rst = 1'b0;
    repeat (3) applyStimulus(0, 2'b00, 32'h0, 32'h0, 2'b00);

    for (int w = 0; w < 20 && expQ.size() > 0; w++) @(posedge clk);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
